// File: rtl/tlb_fsl_pkg.sv
// Shared definitions for the tlb_bram FSL command protocol.
// Covers the header layout (big-endian bit numbering), the control encodings, the FSM states and the error bits.
package tlb_fsl_pkg;

  localparam int WAY_MSB  = 0;
  localparam int WAY_LSB  = 3;
  localparam int ADDR_MSB = 21;
  localparam int ADDR_LSB = 31;

  localparam logic CTL_WR_HDR = 1'b1;
  localparam logic CTL_RD_HDR = 1'b0;
  localparam logic CTL_DATA   = 1'b0;

  localparam int ERR_NO_OUTSTANDING = 0;
  localparam int ERR_CTRL           = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } cmd_state_t;

  function automatic logic [0:31] pack_header(input logic [3:0] way, input logic [10:0] addr);
    logic [0:31] h;
    h = '0;
    h[WAY_MSB:WAY_LSB]   = way;
    h[ADDR_MSB:ADDR_LSB] = addr;
    return h;
  endfunction

endpackage

// File: rtl/tlb_rsp_buf.sv
// One-entry read-response buffer between the FSL slave FIFO and the client.
// A new word is popped whenever the slot is empty or is being drained in the same cycle.
module tlb_rsp_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        s_exists,
  input  logic [31:0] s_data,
  input  logic        s_control,
  output logic        s_read,
  input  logic        rsp_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        pop,
  output logic        pop_ctrl_err
);

  logic        full_reg;
  logic [31:0] data_reg;

  assign pop          = en & s_exists & (~full_reg | rsp_ready);
  assign s_read       = pop;
  assign pop_ctrl_err = pop & s_control;
  assign rsp_valid    = full_reg;
  assign rsp_data     = data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else if (pop) begin
      full_reg <= 1'b1;
      data_reg <= s_data;
    end else if (full_reg && rsp_ready) begin
      full_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/tlb_cmd_master.sv
// FSL initiator for tlb_bram: serialises client read/write requests into header/data words
// and returns read data through a one-entry response buffer, tracking outstanding reads.
module tlb_cmd_master
  import tlb_fsl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        FSL_Clk,
  input  logic        FSL_Rst,
  output logic        FSL_M_Clk,
  output logic        FSL_M_Write,
  output logic [0:31] FSL_M_Data,
  output logic        FSL_M_Control,
  input  logic        FSL_M_Full,
  output logic        FSL_S_Clk,
  output logic        FSL_S_Read,
  input  logic [0:31] FSL_S_Data,
  input  logic        FSL_S_Control,
  input  logic        FSL_S_Exists,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [3:0]  req_way,
  input  logic [10:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [3:0]  outstanding,
  output logic [1:0]  err_flags
);

  localparam logic [3:0] MAX_OS = 4'(MAX_OUTSTANDING);

  cmd_state_t  state_reg, state_next;
  logic        run_reg;
  logic        write_reg;
  logic [3:0]  way_reg;
  logic [10:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  outstanding_reg;
  logic [1:0]  err_reg;
  logic [31:0] s_data_w;
  logic        accept, word_taken, inc, dec_ok, pop, pop_ctrl_err;

  assign FSL_M_Clk   = FSL_Clk;
  assign FSL_S_Clk   = FSL_Clk;
  assign outstanding = outstanding_reg;
  assign err_flags   = err_reg;
  assign s_data_w    = FSL_S_Data;

  assign accept     = req_valid & req_ready;
  assign word_taken = FSL_M_Write & ~FSL_M_Full;
  assign inc        = (state_reg == ST_HDR) & ~write_reg & word_taken;
  assign dec_ok     = pop & (outstanding_reg != 4'd0);

  always_ff @(posedge FSL_Clk or posedge FSL_Rst) begin
    if (FSL_Rst) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_HDR;
      ST_HDR:  if (word_taken) state_next = write_reg ? ST_DATA : ST_IDLE;
      ST_DATA: if (word_taken) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // run_reg holds req_ready low until the first edge after reset releases.
  always_comb begin
    req_ready     = 1'b0;
    FSL_M_Write   = 1'b0;
    FSL_M_Data    = '0;
    FSL_M_Control = 1'b0;
    case (state_reg)
      ST_IDLE: req_ready = run_reg & (req_write | (outstanding_reg < MAX_OS));
      ST_HDR: begin
        FSL_M_Write   = ~FSL_M_Full;
        FSL_M_Data    = pack_header(way_reg, addr_reg);
        FSL_M_Control = write_reg ? CTL_WR_HDR : CTL_RD_HDR;
      end
      ST_DATA: begin
        FSL_M_Write   = ~FSL_M_Full;
        FSL_M_Data    = wdata_reg;
        FSL_M_Control = CTL_DATA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge FSL_Clk or posedge FSL_Rst) begin
    if (FSL_Rst) begin
      run_reg   <= 1'b0;
      write_reg <= 1'b0;
      way_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      run_reg <= 1'b1;
      if (accept) begin
        write_reg <= req_write;
        way_reg   <= req_way;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
    end
  end

  // A pop with nothing outstanding does not decrement but is still delivered and flagged.
  always_ff @(posedge FSL_Clk or posedge FSL_Rst) begin
    if (FSL_Rst) begin
      outstanding_reg <= '0;
      err_reg         <= '0;
    end else begin
      case ({inc, dec_ok})
        2'b10:   outstanding_reg <= outstanding_reg + 4'd1;
        2'b01:   outstanding_reg <= outstanding_reg - 4'd1;
        default: outstanding_reg <= outstanding_reg;
      endcase
      if (pop && outstanding_reg == 4'd0) err_reg[ERR_NO_OUTSTANDING] <= 1'b1;
      if (pop_ctrl_err)                   err_reg[ERR_CTRL]           <= 1'b1;
    end
  end

  tlb_rsp_buf u_rsp_buf (
    .clk          (FSL_Clk),
    .rst          (FSL_Rst),
    .en           (run_reg),
    .s_exists     (FSL_S_Exists),
    .s_data       (s_data_w),
    .s_control    (FSL_S_Control),
    .s_read       (FSL_S_Read),
    .rsp_ready    (rsp_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .pop          (pop),
    .pop_ctrl_err (pop_ctrl_err)
  );

endmodule

// File: tb/tb_tlb_cmd_master.sv
// Scoreboard bench for tlb_cmd_master: expected FSL words and client responses are queued
// at issue time and checked by an independent monitor; directed checks cover timing and flags.
`timescale 1ns/1ps
module tb_tlb_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_clk, m_write, m_control, m_full;
  logic [31:0] m_data;
  logic        s_clk, s_read, s_control, s_exists;
  logic [31:0] s_data;
  logic        req_valid, req_ready, req_write;
  logic [3:0]  req_way;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  outstanding;
  logic [1:0]  err_flags;

  int errors  = 0;
  int checks  = 0;
  int m_words = 0;
  int base;

  logic [32:0] exp_m_q[$];
  logic [31:0] exp_rsp_q[$];
  logic [32:0] s_q[$];
  logic [32:0] mon_e;
  logic [31:0] mon_r;
  logic        sd_pop;

  always #5 clk = ~clk;

  tlb_cmd_master #(.MAX_OUTSTANDING(4)) dut (
    .FSL_Clk       (clk),
    .FSL_Rst       (rst),
    .FSL_M_Clk     (m_clk),
    .FSL_M_Write   (m_write),
    .FSL_M_Data    (m_data),
    .FSL_M_Control (m_control),
    .FSL_M_Full    (m_full),
    .FSL_S_Clk     (s_clk),
    .FSL_S_Read    (s_read),
    .FSL_S_Data    (s_data),
    .FSL_S_Control (s_control),
    .FSL_S_Exists  (s_exists),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_way       (req_way),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .outstanding   (outstanding),
    .err_flags     (err_flags)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic void drive_s();
    if (s_q.size() > 0) begin
      s_exists  = 1'b1;
      s_data    = s_q[0][31:0];
      s_control = s_q[0][32];
    end else begin
      s_exists  = 1'b0;
      s_data    = '0;
      s_control = 1'b0;
    end
  endfunction

  task automatic inject(input logic [31:0] d, input logic ctl, input logic expect_rsp);
    s_q.push_back({ctl, d});
    if (expect_rsp) exp_rsp_q.push_back(d);
    drive_s();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept();
    bit got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(posedge clk);
      if (req_ready) got = 1'b1;
    end
    #1;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready stayed 0, required 1");
    end
  endtask

  task automatic do_req(input logic wr, input logic [3:0] way, input logic [10:0] addr,
                        input logic [31:0] wd, input logic expect_words);
    if (expect_words) begin
      exp_m_q.push_back({wr, way, 17'b0, addr});
      if (wr) exp_m_q.push_back({1'b0, wd});
    end
    req_write = wr;
    req_way   = way;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    wait_accept();
    req_valid = 1'b0;
  endtask

  // Response FIFO model: pops on the edge where the DUT's read strobe was high.
  initial forever begin
    @(posedge clk);
    sd_pop = s_read;
    #1;
    if (sd_pop && s_q.size() > 0) void'(s_q.pop_front());
    drive_s();
  end

  // Monitor: every accepted FSL word and every consumed response is checked against the queues.
  initial forever begin
    @(negedge clk);
    if (m_write && !m_full) begin
      m_words++;
      if (exp_m_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fsl_word: got %h ctl %b, required no word", m_data, m_control);
      end else begin
        mon_e = exp_m_q.pop_front();
        check("fsl_word_data", m_data, mon_e[31:0]);
        check("fsl_word_ctl", {31'b0, m_control}, {31'b0, mon_e[32]});
      end
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_word: got %h, required no response", rsp_data);
      end else begin
        mon_r = exp_rsp_q.pop_front();
        check("rsp_word", rsp_data, mon_r);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m_full    = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_way   = '0;
    req_addr  = '0;
    req_wdata = '0;
    drive_s();

    // Reset state
    repeat (3) tick();
    check("rst_m_write", {31'b0, m_write}, 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_outstanding", {28'b0, outstanding}, 32'd0);
    check("rst_err", {30'b0, err_flags}, 32'd0);
    rst = 1'b0;
    tick();
    check("first_req_ready", {31'b0, req_ready}, 32'd1);

    // Write way 2, addr 5
    do_req(1'b1, 4'd2, 11'd5, 32'h0000_0002, 1'b1);
    check("wr_hdr_data", m_data, 32'h2000_0005);
    check("wr_hdr_ctl", {31'b0, m_control}, 32'd1);
    check("wr_hdr_strobe", {31'b0, m_write}, 32'd1);
    tick();
    check("wr_data_word", m_data, 32'h0000_0002);
    check("wr_data_ctl", {31'b0, m_control}, 32'd0);
    tick();
    check("wr_ready_again", {31'b0, req_ready}, 32'd1);

    // Read way 8, addr 9, then its response
    do_req(1'b0, 4'd8, 11'd9, 32'h0, 1'b1);
    check("rd_hdr_data", m_data, 32'h8000_0009);
    check("rd_hdr_ctl", {31'b0, m_control}, 32'd0);
    tick();
    check("rd_outstanding", {28'b0, outstanding}, 32'd1);
    inject(32'hDEAD_BEEF, 1'b0, 1'b1);
    tick();
    check("rd_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("rd_rsp_data", rsp_data, 32'hDEAD_BEEF);
    check("rd_outstanding_zero", {28'b0, outstanding}, 32'd0);
    check("rd_err", {30'b0, err_flags}, 32'd0);
    tick();

    // Outstanding limit
    base = m_words;
    for (int i = 0; i < 4; i++) do_req(1'b0, 4'd1, 11'(i), 32'h0, 1'b1);
    tick();
    exp_m_q.push_back({1'b0, 4'd4, 17'b0, 11'd4});
    req_write = 1'b0;
    req_way   = 4'd4;
    req_addr  = 11'd4;
    req_valid = 1'b1;
    repeat (3) tick();
    check("lim_req_ready", {31'b0, req_ready}, 32'd0);
    check("lim_outstanding", {28'b0, outstanding}, 32'd4);
    check("lim_headers", 32'(m_words - base), 32'd4);
    inject(32'h0000_0100, 1'b0, 1'b1);
    wait_accept();
    req_valid = 1'b0;
    check("lim_5th_hdr", m_data, 32'h4000_0004);
    tick();
    check("lim_headers_5", 32'(m_words - base), 32'd5);
    for (int i = 1; i <= 4; i++) inject(32'h0000_0100 + 32'(i), 1'b0, 1'b1);
    for (int n = 0; n < 30 && outstanding != 4'd0; n++) tick();
    check("lim_drain", {28'b0, outstanding}, 32'd0);
    tick();

    // Backpressure in DATA
    base = m_words;
    do_req(1'b1, 4'd1, 11'h7FF, 32'hCAFE_F00D, 1'b1);
    tick();
    m_full = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("stall_no_strobe", {31'b0, m_write}, 32'd0);
      check("stall_data_stable", m_data, 32'hCAFE_F00D);
    end
    m_full = 1'b0;
    tick();
    check("stall_words_total", 32'(m_words - base), 32'd2);
    tick();

    // Error flags
    inject(32'h1111_1111, 1'b0, 1'b1);
    tick();
    check("err_no_outstanding", {30'b0, err_flags}, 32'd1);
    inject(32'h2222_2222, 1'b1, 1'b1);
    tick();
    check("err_ctrl", {30'b0, err_flags}, 32'd3);
    check("err_ctrl_data", rsp_data, 32'h2222_2222);
    tick();

    // Asynchronous reset while stalled in HDR with a response held
    rsp_ready = 1'b0;
    inject(32'h3333_3333, 1'b0, 1'b0);
    tick();
    check("pre_rst_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    m_full    = 1'b1;
    req_write = 1'b0;
    req_way   = 4'd3;
    req_addr  = 11'd3;
    req_valid = 1'b1;
    wait_accept();
    req_valid = 1'b0;
    tick();
    check("pre_rst_hdr", m_data, 32'h3000_0003);
    #2 rst = 1'b1;
    #1;
    check("arst_m_write", {31'b0, m_write}, 32'd0);
    check("arst_m_data", m_data, 32'd0);
    check("arst_m_ctl", {31'b0, m_control}, 32'd0);
    check("arst_s_read", {31'b0, s_read}, 32'd0);
    check("arst_req_ready", {31'b0, req_ready}, 32'd0);
    check("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("arst_rsp_data", rsp_data, 32'd0);
    check("arst_outstanding", {28'b0, outstanding}, 32'd0);
    check("arst_err", {30'b0, err_flags}, 32'd0);
    @(posedge clk);
    #2;
    rst       = 1'b0;
    m_full    = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("post_rst_idle_ready", {31'b0, req_ready}, 32'd1);
    check("post_rst_no_strobe", {31'b0, m_write}, 32'd0);

    repeat (3) tick();
    check("fsl_queue_empty", 32'(exp_m_q.size()), 32'd0);
    check("rsp_queue_empty", 32'(exp_rsp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlb_cmd_master.md
# tlb_cmd_master

FSL initiator for the `tlb_bram` cache/TLB store. It accepts single-word read/write requests from a local client. It serialises each request into the `tlb_bram` command format on an FSL master port, and returns read data from the FSL slave port to the client. It sits between a cache controller or other client logic and the two FSL links that connect to `tlb_bram`.

## Interface
- `MAX_OUTSTANDING`, default 4: maximum read headers sent whose data has not yet returned (1..15).
- `FSL_Clk` in 1: the only clock.
- `FSL_Rst` in 1: reset, asynchronous, active-high.
- `FSL_M_Clk` out 1: tied to `FSL_Clk`.
- `FSL_M_Write` out 1: write strobe toward `tlb_bram` slave FIFO.
- `FSL_M_Data` out [0:31]: command/data word.
- `FSL_M_Control` out 1: 1 on a write header, 0 otherwise.
- `FSL_M_Full` in 1: FIFO full; a word is taken only on an edge where `FSL_M_Write` is high and `FSL_M_Full` is low.
- `FSL_S_Clk` out 1: tied to `FSL_Clk`.
- `FSL_S_Read` out 1: pop strobe for the response FIFO.
- `FSL_S_Data` in [0:31]: read response word.
- `FSL_S_Control` in 1: response control bit; 1 is a protocol error.
- `FSL_S_Exists` in 1: response FIFO non-empty.
- `req_valid` in 1: client request present.
- `req_ready` out 1: request accepted on an edge where `req_valid` and `req_ready` are both high.
- `req_write` in 1: 1 = write, 0 = read.
- `req_way` in 4: one-hot way select.
- `req_addr` in 11: set index.
- `req_wdata` in 32: write data.
- `rsp_valid` out 1: read data available.
- `rsp_ready` in 1: client consumes `rsp_data` on an edge where `rsp_valid` and `rsp_ready` are both high.
- `rsp_data` out 32: read data.
- `outstanding` out 4: current outstanding-read count.
- `err_flags` out 2: sticky error flags. Bit 0 = response arrived with `outstanding`==0. Bit 1 = response with `FSL_S_Control`=1.

## Operation
- Header word, in FSL big-endian bit order: bits [0:3] = way, bits [4:20] = 0, bits [21:31] = addr.
- Write sends two words: the header with control=1, then `req_wdata` with control=0.
- Read sends one word: the header with control=0. `tlb_bram` returns exactly one data word per read, in order.
- Command FSM states:
  - IDLE: `req_ready` = (`req_write` | (`outstanding` < `MAX_OUTSTANDING`)). On accept, latch way/addr/wdata/write and go to HDR.
  - HDR: drive the header and `FSL_M_Write` = !`FSL_M_Full`. When the word is taken: on a write go to DATA; on a read increment `outstanding` and go to IDLE.
  - DATA: drive the latched wdata and `FSL_M_Write` = !`FSL_M_Full`. When the word is taken go to IDLE.
- A stalled FSL (`FSL_M_Full`=1) holds HDR/DATA indefinitely with `FSL_M_Data` and `FSL_M_Control` stable.
- Response path: one-entry buffer.
  - `FSL_S_Read` = `FSL_S_Exists` & (buffer empty | (`rsp_valid` & `rsp_ready`)).
  - A popped word loads the buffer.
  - On a pop, `outstanding` decrements, saturating at 0. At 0, set `err_flags`[0] and still deliver the word to the client.
  - `FSL_S_Control`=1 on a pop sets `err_flags`[1]; the data is delivered unchanged.
- Increment and decrement of `outstanding` in the same cycle: the count is unchanged.
- `err_flags` clear only on reset.

## Timing
- All state is registered on rising `FSL_Clk`. `FSL_Rst` clears it immediately, without waiting for a clock edge.
- Reset values:
  - `FSL_M_Write`=0, `FSL_M_Data`=0, `FSL_M_Control`=0
  - `FSL_S_Read`=0, `req_ready`=0, `rsp_valid`=0, `rsp_data`=0
  - `outstanding`=0, `err_flags`=0, FSM=IDLE
- The first `req_ready` can rise in the first cycle after reset deasserts.
- Throughput with no backpressure: a write occupies 3 cycles (IDLE, HDR, DATA); a read occupies 2 cycles (IDLE, HDR).
- Header appears on `FSL_M_Data` one cycle after the accept edge.
- Read latency: from `FSL_S_Exists` seen with an empty buffer, `rsp_valid` rises at the next edge.
- Back-to-back responses stream at 1 word/cycle while `rsp_ready`=1.
- Reset mid-command abandons it. A write header already sent without its data word is not recoverable: the system resets `tlb_bram` together with this block.

## Structure
- Shared package `tlb_fsl_pkg`:
  - header field positions (WAY_MSB/LSB, ADDR_MSB/LSB)
  - control encodings
  - FSM state encoding (IDLE/HDR/DATA)
  - error-bit indices
  - header-pack function
- Optional sub-module `tlb_rsp_buf`: the one-entry response buffer with its pop logic. The command FSM stays in the top level.

## Test plan
- Write way=4'd2, addr=11'd5, data=32'h0000_0002, with `FSL_M_Full`=0:
  - cycle N+1: `FSL_M_Data`=32'h2000_0005 with control=1
  - cycle N+2: 32'h0000_0002 with control=0
  - `req_ready` high again at N+3.
- Read way=4'd8, addr=11'd9: one word 32'h8000_0009 with control=0, and `outstanding`=1. Inject response 32'hDEAD_BEEF: `rsp_valid` with that data, `outstanding`=0.
- Issue 5 reads with `MAX_OUTSTANDING`=4 and no responses: 4 headers sent, `req_ready`=0 on the 5th. Return one response: the 5th header is sent.
- Hold `FSL_M_Full`=1 for 7 cycles during a write DATA state: no write strobe, `FSL_M_Data` stable. After release, exactly 2 words are sent in total.
- Inject a response with `outstanding`=0, then one with `FSL_S_Control`=1: `err_flags`=2'b01, then 2'b11, and both words are delivered.
- Assert `FSL_Rst` for 1 cycle in HDR with `rsp_valid`=1: all outputs immediately take their reset values, and the FSM is in IDLE.
